// File: rtl/ins_fetch_ctrl_if.sv
// Bundle of the fetch-stage, buffer-write and instruction-memory signals
// around the instruction-window refill controller.
interface ins_fetch_ctrl_if #(
   parameter int unsigned DEPTH = 128
) ();
   localparam int unsigned IW = $clog2(DEPTH);

   logic          fetch_req;
   logic [31:0]   fetch_pc;
   logic          flush;
   logic          stall;
   logic [IW-1:0] buf_index;
   logic [31:0]   buf_base;
   logic          win_valid;
   logic          buf_we;
   logic [IW-1:0] buf_waddr;
   logic [31:0]   buf_wdata;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;

   modport master (
      input  fetch_req, fetch_pc, flush, mem_gnt, mem_rvalid, mem_rdata,
      output stall, buf_index, buf_base, win_valid,
             buf_we, buf_waddr, buf_wdata, mem_req, mem_addr
   );

   modport slave (
      output fetch_req, fetch_pc, flush, mem_gnt, mem_rvalid, mem_rdata,
      input  stall, buf_index, buf_base, win_valid,
             buf_we, buf_waddr, buf_wdata, mem_req, mem_addr
   );
endinterface

// File: rtl/ins_fetch_ctrl.sv
// Instruction-window refill controller: classifies fetches as hit/miss
// against the current window and refills the whole aligned window from
// instruction memory one word at a time on a miss.
module ins_fetch_ctrl #(
   parameter int unsigned DEPTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   ins_fetch_ctrl_if.master bus
);
   localparam int unsigned IW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [IW:0]   cnt_q, cnt_d;
   logic [31:0]   new_base_q, new_base_d;
   logic          flush_pend_q, flush_pend_d;
   logic [31:0]   buf_base_q, buf_base_d;
   logic          win_valid_q, win_valid_d;
   logic          buf_we_q, buf_we_d;
   logic [IW-1:0] buf_waddr_q, buf_waddr_d;
   logic [31:0]   buf_wdata_q, buf_wdata_d;

   logic [31:0]   pc_off;
   logic          hit;

   // Unsigned offset: a pc below the base wraps to a large value and misses.
   assign pc_off        = bus.fetch_pc - buf_base_q;
   assign hit           = win_valid_q && (pc_off < 32'(DEPTH));
   assign bus.stall     = bus.fetch_req && !hit;
   assign bus.buf_index = pc_off[IW-1:0];

   assign bus.mem_req   = (state_q == ST_ISSUE);
   assign bus.mem_addr  = new_base_q + 32'(cnt_q);
   assign bus.buf_base  = buf_base_q;
   assign bus.win_valid = win_valid_q;
   assign bus.buf_we    = buf_we_q;
   assign bus.buf_waddr = buf_waddr_q;
   assign bus.buf_wdata = buf_wdata_q;

   // Next-state and register-update logic for the refill sequence.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      new_base_d   = new_base_q;
      flush_pend_d = flush_pend_q;
      buf_base_d   = buf_base_q;
      win_valid_d  = win_valid_q;
      buf_we_d     = 1'b0;
      buf_waddr_d  = buf_waddr_q;
      buf_wdata_d  = buf_wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.flush) begin
               win_valid_d = 1'b0;
            end else if (bus.fetch_req && !hit) begin
               new_base_d  = bus.fetch_pc & ~(32'(DEPTH) - 32'd1);
               cnt_d       = '0;
               win_valid_d = 1'b0;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.flush) flush_pend_d = 1'b1;
            if (bus.mem_gnt) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.flush) flush_pend_d = 1'b1;
            // After the last beat cnt reads DEPTH; one extra WAIT cycle
            // publishes the base the cycle after the final buffer write.
            if (cnt_q[IW]) begin
               buf_base_d   = new_base_q;
               win_valid_d  = !(flush_pend_q || bus.flush);
               flush_pend_d = 1'b0;
               state_d      = ST_IDLE;
            end else if (bus.mem_rvalid) begin
               buf_we_d    = 1'b1;
               buf_waddr_d = cnt_q[IW-1:0];
               buf_wdata_d = bus.mem_rdata;
               cnt_d       = cnt_q + (IW+1)'(1);
               if (cnt_q[IW-1:0] != '1) state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         new_base_q   <= '0;
         flush_pend_q <= 1'b0;
         buf_base_q   <= '0;
         win_valid_q  <= 1'b0;
         buf_we_q     <= 1'b0;
         buf_waddr_q  <= '0;
         buf_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         new_base_q   <= new_base_d;
         flush_pend_q <= flush_pend_d;
         buf_base_q   <= buf_base_d;
         win_valid_q  <= win_valid_d;
         buf_we_q     <= buf_we_d;
         buf_waddr_q  <= buf_waddr_d;
         buf_wdata_q  <= buf_wdata_d;
      end
   end
endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Randomised bench for ins_fetch_ctrl with a transaction-level model of the
// window (valid/base) and of the refill traffic it must generate.
module tb_ins_fetch_ctrl;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic rst;

   ins_fetch_ctrl_if #(.DEPTH(DEPTH)) bus ();

   ins_fetch_ctrl #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   bit          chk_en;

   // stimulus knobs
   int unsigned p_req, p_flush, p_gnt, p_stray;
   bit          fix_pc;
   logic [31:0] pc_val;

   // reference model
   bit          m_valid;
   logic [31:0] m_base;
   bit          m_busy;
   logic [31:0] m_target;
   int unsigned m_issued, m_written;
   bit          m_flushed, m_commit;
   bit          outstanding, orphan;
   int unsigned rv_wait;
   logic [31:0] out_addr;
   bit          exp_we;
   int unsigned exp_waddr;
   logic [31:0] exp_wdata;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_win_valid"}, 32'(bus.win_valid), 32'h0);
      check({tag, "_buf_base"},  bus.buf_base,        32'h0);
      check({tag, "_buf_we"},    32'(bus.buf_we),    32'h0);
      check({tag, "_buf_waddr"}, 32'(bus.buf_waddr), 32'h0);
      check({tag, "_buf_wdata"}, bus.buf_wdata,       32'h0);
      check({tag, "_mem_req"},   32'(bus.mem_req),   32'h0);
      check({tag, "_mem_addr"},  bus.mem_addr,        32'h0);
   endtask

   // One clock cycle: drive inputs, compare outputs, advance the model.
   task automatic step(input bit do_rst);
      logic [31:0] d;
      bit hit, exp_req, deliver, stray, mreq_now, exp_we_n, set_commit;
      @(negedge clk);
      mreq_now = (bus.mem_req === 1'b1);
      rst = do_rst;
      bus.fetch_req = ($urandom_range(0, 99) < p_req);
      if (fix_pc)                           bus.fetch_pc = pc_val;
      else if ($urandom_range(0, 19) == 0) bus.fetch_pc = $urandom;
      else                                  bus.fetch_pc = $urandom_range(0, 47);
      bus.flush   = ($urandom_range(0, 99) < p_flush);
      bus.mem_gnt = mreq_now && ($urandom_range(0, 99) < p_gnt);
      deliver = 1'b0;
      if (outstanding) begin
         if (rv_wait == 0) deliver = 1'b1;
         else rv_wait--;
      end
      stray = !outstanding && (!m_busy || (mreq_now && !bus.mem_gnt))
              && ($urandom_range(0, 99) < p_stray);
      bus.mem_rvalid = deliver || stray;
      bus.mem_rdata  = deliver ? memfn(out_addr) : $urandom;
      #1;
      d       = bus.fetch_pc - m_base;
      hit     = m_valid && (d < 32'(DEPTH));
      exp_req = m_busy && !(outstanding && !orphan) && (m_issued < DEPTH);
      if (chk_en) begin
         check("win_valid", 32'(bus.win_valid), 32'(m_valid));
         check("buf_base",  bus.buf_base,        m_base);
         check("stall",     32'(bus.stall),     32'(bus.fetch_req && !hit));
         check("buf_index", 32'(bus.buf_index), d % 32'(DEPTH));
         check("mem_req",   32'(bus.mem_req),   32'(exp_req));
         if (exp_req) check("mem_addr", bus.mem_addr, m_target + m_issued);
         check("buf_we",    32'(bus.buf_we),    32'(exp_we));
         if (exp_we) begin
            check("buf_waddr", 32'(bus.buf_waddr), exp_waddr);
            check("buf_wdata", bus.buf_wdata,       exp_wdata);
         end
      end
      exp_we_n   = 1'b0;
      set_commit = 1'b0;
      if (do_rst) begin
         if (deliver) outstanding = 1'b0;
         else if (outstanding) orphan = 1'b1;
         m_valid = 1'b0; m_base = '0; m_busy = 1'b0; m_commit = 1'b0;
         m_flushed = 1'b0; m_issued = 0; m_written = 0;
      end else begin
         if (deliver) begin
            outstanding = 1'b0;
            if (orphan) orphan = 1'b0;
            else begin
               exp_we_n  = 1'b1;
               exp_waddr = m_written;
               exp_wdata = memfn(m_target + m_written);
               m_written++;
               if (m_written == DEPTH) set_commit = 1'b1;
            end
         end
         if (bus.mem_gnt && exp_req) begin
            outstanding = 1'b1;
            rv_wait     = $urandom_range(0, 2);
            out_addr    = m_target + m_issued;
            m_issued++;
         end
         if (m_commit) begin
            m_commit = 1'b0;
            m_busy   = 1'b0;
            m_valid  = !(m_flushed || bus.flush);
            m_base   = m_target;
         end else if (!m_busy) begin
            if (bus.flush) m_valid = 1'b0;
            else if (bus.fetch_req && !hit) begin
               m_busy    = 1'b1;
               m_valid   = 1'b0;
               m_target  = bus.fetch_pc & ~(32'(DEPTH) - 32'd1);
               m_issued  = 0;
               m_written = 0;
               m_flushed = 1'b0;
            end
         end else if (bus.flush) begin
            m_flushed = 1'b1;
         end
         if (set_commit) m_commit = 1'b1;
      end
      exp_we = exp_we_n;
   endtask

   task automatic settle(input int unsigned budget, input string tag);
      int unsigned n = 0;
      while ((m_busy || outstanding) && n < budget) begin
         step(1'b0);
         n++;
      end
      check({tag, "_settle"}, 32'(!(m_busy || outstanding)), 32'h1);
   endtask

   initial begin
      int unsigned n;
      rst = 1'b1;
      bus.fetch_req = 1'b0; bus.fetch_pc = '0; bus.flush = 1'b0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      chk_en = 1'b0;
      p_req = 0; p_flush = 0; p_gnt = 100; p_stray = 0;
      fix_pc = 1'b1; pc_val = '0;
      m_valid = 1'b0; m_base = '0; m_busy = 1'b0; m_target = '0;
      m_issued = 0; m_written = 0; m_flushed = 1'b0; m_commit = 1'b0;
      outstanding = 1'b0; orphan = 1'b0; rv_wait = 0; out_addr = '0;
      exp_we = 1'b0; exp_waddr = 0; exp_wdata = '0;

      step(1'b1);
      step(1'b1);
      @(posedge clk); #1;
      check_reset("reset");
      chk_en = 1'b1;

      // cold fill of window 0
      p_req = 100; pc_val = 32'h0;
      step(1'b0);
      settle(200, "fill0");
      step(1'b0);
      check("fill0_valid", 32'(bus.win_valid), 32'h1);
      check("fill0_base",  bus.buf_base,        32'h0);
      check("fill0_stall", 32'(bus.stall),     32'h0);

      // window at 0x8, hit at its top word, then miss just above
      pc_val = 32'h8;
      step(1'b0);
      settle(200, "fill8");
      pc_val = 32'hF;
      step(1'b0);
      check("hit_index", 32'(bus.buf_index), 32'h7);
      check("hit_stall", 32'(bus.stall),     32'h0);
      check("hit_noreq", 32'(bus.mem_req),   32'h0);
      pc_val = 32'h10;
      step(1'b0);
      settle(200, "fill10");
      step(1'b0);
      check("fill10_base", bus.buf_base, 32'h10);

      // pc below the base wraps and misses
      pc_val = 32'h3;
      step(1'b0);
      check("wrap_stall", 32'(bus.stall), 32'h1);
      settle(200, "wrap");
      step(1'b0);
      check("wrap_base",  bus.buf_base,        32'h0);
      check("wrap_valid", 32'(bus.win_valid), 32'h1);

      // grant withheld with stray read data in ISSUE
      pc_val = 32'h28; p_gnt = 0; p_stray = 100;
      step(1'b0);
      repeat (6) step(1'b0);
      check("gnt_hold_req",  32'(bus.mem_req), 32'h1);
      check("gnt_hold_addr", bus.mem_addr,      32'h28);
      p_gnt = 70; p_stray = 20;
      settle(300, "gnt_hold");

      // flush in the middle of a refill
      pc_val = 32'h30;
      step(1'b0);
      repeat (5) step(1'b0);
      p_flush = 100;
      step(1'b0);
      p_flush = 0;
      settle(300, "flush");
      step(1'b0);
      check("flush_valid",   32'(bus.win_valid), 32'h0);
      check("flush_restall", 32'(bus.stall),     32'h1);
      settle(300, "flush_refill");

      // random traffic
      fix_pc = 1'b0; p_req = 70; p_flush = 3; p_gnt = 60; p_stray = 10;
      repeat (2000) step(1'b0);
      p_req = 0; p_flush = 0;
      settle(400, "random");

      // reset while waiting for the fourth word
      fix_pc = 1'b1; pc_val = 32'h40; p_req = 100; p_gnt = 100; p_stray = 0;
      n = 0;
      step(1'b0);
      while (!(m_written == 3 && outstanding) && n < 100) begin
         step(1'b0);
         n++;
      end
      check("rst_mid_reach", 32'(m_written == 3 && outstanding), 32'h1);
      p_req = 0;
      step(1'b1);
      @(posedge clk); #1;
      check_reset("rst_mid");
      repeat (5) step(1'b0);
      check("rst_orphan_done", 32'(outstanding), 32'h0);
      check("rst_mid_after_valid", 32'(bus.win_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
